if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 26 ++
 rtl/if_stage.sv | 158 +++++++++++++++
 tb/tb_if_stage.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// if_stage_if -- instruction-memory bus between the fetch stage and memory.
//   imem_req   : stage -> memory, request a word this cycle
//   imem_addr  : stage -> memory, fetch address (word in flight)
//   imem_rdata : memory -> stage, instruction word, valid with imem_ready
//   imem_ready : memory -> stage, completes the current request this cycle
// master = fetch stage side, slave = memory side.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage with IF/ID pipeline register.
// Fetches through a variable-latency memory bus, supports stalls (wpcir),
// redirects (jr > jump > branch, no delay slot) and a one-entry buffer that
// parks a word which arrives while ID is stalled.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   wpcir               : 1 = hold PC and IF/ID
//   jump, jr, branch    : redirect requests from ID
//   jr_target           : forwarded rs value for JR
//   imem                : instruction-memory bus (master side)
//   pc                  : address of the instruction being fetched
//   id_inst, id_pc4     : IF/ID instruction and PC+4 registers
//   id_valid            : 0 = id_inst is a NOP bubble
//   fetch_busy          : 1 while in WAIT or HOLD
module if_stage (
  input  logic             clk,
  input  logic             reset,
  input  logic             wpcir,
  input  logic             jump,
  input  logic             jr,
  input  logic             branch,
  input  logic [31:0]      jr_target,
  if_stage_if.master       imem,
  output logic [31:0]      pc,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic             fetch_busy
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic        discard;   // outstanding response belongs to a flushed path
  logic [31:0] buffer;    // word that completed while ID was stalled
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect   = jr | jump | branch;
  assign pc_plus4   = pc + 32'd4;   // wraps modulo 2^32
  assign fetch_busy = (state != S_FETCH);
  assign imem.imem_addr = pc;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    target = id_pc4 + {{14{id_inst[15]}}, id_inst[15:0], 2'b00};
    if (jr)
      target = jr_target;
    else if (jump)
      target = {id_pc4[31:28], id_inst[25:0], 2'b00};
  end

  always_comb begin
    imem.imem_req = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: imem.imem_req = ~wpcir | redirect;
        S_WAIT:  imem.imem_req = 1'b1;
        default: imem.imem_req = 1'b0;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      id_inst  <= '0;
      id_pc4   <= '0;
      id_valid <= 1'b0;
      discard  <= 1'b0;
      buffer   <= '0;
    end else if (redirect) begin
      // Flush: no delay slot, id_pc4 keeps its value.
      pc       <= target;
      id_inst  <= '0;
      id_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!imem.imem_ready) begin
            state   <= S_WAIT;
            discard <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_ready) begin
            state   <= S_FETCH;
            discard <= 1'b0;
          end else begin
            discard <= 1'b1;
          end
        end
        default: begin
          buffer <= '0;
          state  <= S_FETCH;
        end
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          // With wpcir=1 no request is issued and everything holds.
          if (!wpcir) begin
            if (imem.imem_ready) begin
              id_inst  <= imem.imem_rdata;
              id_pc4   <= pc_plus4;
              id_valid <= 1'b1;
              pc       <= pc_plus4;
            end else begin
              id_inst  <= '0;
              id_valid <= 1'b0;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem.imem_ready) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_FETCH;
              if (!wpcir) begin
                id_inst  <= '0;
                id_valid <= 1'b0;
              end
            end else if (!wpcir) begin
              id_inst  <= imem.imem_rdata;
              id_pc4   <= pc_plus4;
              id_valid <= 1'b1;
              pc       <= pc_plus4;
              state    <= S_FETCH;
            end else begin
              buffer <= imem.imem_rdata;
              state  <= S_HOLD;
            end
          end else if (!wpcir) begin
            id_inst  <= '0;
            id_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!wpcir) begin
            id_inst  <= buffer;
            id_pc4   <= pc_plus4;
            id_valid <= 1'b1;
            pc       <= pc_plus4;
            buffer   <= '0;
            state    <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- directed, table-driven bench for if_stage.
// Each vector drives one cycle of inputs, checks the combinational bus
// outputs before the edge and the registered outputs just after it.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        wpcir;
  logic        jump;
  logic        jr;
  logic        branch;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        fetch_busy;

  if_stage_if imem_bus ();

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .wpcir      (wpcir),
    .jump       (jump),
    .jr         (jr),
    .branch     (branch),
    .jr_target  (jr_target),
    .imem       (imem_bus.master),
    .pc         (pc),
    .id_inst    (id_inst),
    .id_pc4     (id_pc4),
    .id_valid   (id_valid),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wpcir, jr, jump, branch, ready;
    logic [31:0] jr_target, rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc, exp_inst, exp_pc4;
    logic        exp_valid, exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  task automatic add(input logic w, input logic r_jr, input logic r_j,
                     input logic r_b, input logic rdy, input logic [31:0] tgt,
                     input logic [31:0] rd, input logic ereq,
                     input logic [31:0] eaddr, input logic [31:0] epc,
                     input logic [31:0] einst, input logic [31:0] epc4,
                     input logic evalid, input logic ebusy);
    vec_t v;
    v.wpcir = w; v.jr = r_jr; v.jump = r_j; v.branch = r_b; v.ready = rdy;
    v.jr_target = tgt; v.rdata = rd;
    v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_pc = epc; v.exp_inst = einst; v.exp_pc4 = epc4;
    v.exp_valid = evalid; v.exp_busy = ebusy;
    vecs.push_back(v);
  endtask

  task automatic check_regs(input string tag, input logic [31:0] epc,
                            input logic [31:0] einst, input logic [31:0] epc4,
                            input logic evalid, input logic ebusy);
    check({tag, "_pc"},    pc,         epc);
    check({tag, "_inst"},  id_inst,    einst);
    check({tag, "_pc4"},   id_pc4,     epc4);
    check({tag, "_valid"}, {31'd0, id_valid},   {31'd0, evalid});
    check({tag, "_busy"},  {31'd0, fetch_busy}, {31'd0, ebusy});
  endtask

  initial begin
    reset = 1'b1; wpcir = 1'b0; jump = 1'b0; jr = 1'b0; branch = 1'b0;
    jr_target = '0;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = '0;

    // Fields: wpcir jr jump branch ready jr_target rdata |
    //         req addr | pc inst pc4 valid busy
    // Back-to-back fetch
    add(0,0,0,0,1, 0, 32'h11111100, 1, 32'h00, 32'h04, 32'h11111100, 32'h04, 1, 0);
    add(0,0,0,0,1, 0, 32'h11111104, 1, 32'h04, 32'h08, 32'h11111104, 32'h08, 1, 0);
    add(0,0,0,0,1, 0, 32'h11111108, 1, 32'h08, 32'h0C, 32'h11111108, 32'h0C, 1, 0);
    add(0,0,0,0,1, 0, 32'h1111110C, 1, 32'h0C, 32'h10, 32'h1111110C, 32'h10, 1, 0);
    // Two wait states at 0x10
    add(0,0,0,0,0, 0, 32'h0,        1, 32'h10, 32'h10, 32'h0,        32'h10, 0, 1);
    add(0,0,0,0,0, 0, 32'h0,        1, 32'h10, 32'h10, 32'h0,        32'h10, 0, 1);
    add(0,0,0,0,1, 0, 32'h22220010, 1, 32'h10, 32'h14, 32'h22220010, 32'h14, 1, 0);
    // Stall while WAIT completes -> HOLD, then release
    add(0,0,0,0,0, 0, 32'h0,        1, 32'h14, 32'h14, 32'h0,        32'h14, 0, 1);
    add(1,0,0,0,0, 0, 32'h0,        1, 32'h14, 32'h14, 32'h0,        32'h14, 0, 1);
    add(1,0,0,0,1, 0, 32'h33330014, 1, 32'h14, 32'h14, 32'h0,        32'h14, 0, 1);
    add(1,0,0,0,0, 0, 32'h0,        0, 32'h14, 32'h14, 32'h0,        32'h14, 0, 1);
    add(0,0,0,0,0, 0, 32'h0,        0, 32'h14, 32'h18, 32'h33330014, 32'h18, 1, 0);
    // Stall in FETCH: no request, spurious ready ignored, all held
    add(1,0,0,0,1, 0, 32'hBAD0BAD0, 0, 32'h18, 32'h18, 32'h33330014, 32'h18, 1, 0);
    add(0,0,0,0,1, 0, 32'h44440018, 1, 32'h18, 32'h1C, 32'h44440018, 32'h1C, 1, 0);
    add(0,0,0,0,1, 0, 32'h08000040, 1, 32'h1C, 32'h20, 32'h08000040, 32'h20, 1, 0);
    // Jump with request outstanding at 0x20: target 0x100, late word dropped
    add(0,0,1,0,0, 0, 32'h0,        1, 32'h20, 32'h100, 32'h0,       32'h20, 0, 1);
    add(0,0,0,0,0, 0, 32'h0,        1, 32'h100, 32'h100, 32'h0,      32'h20, 0, 1);
    add(0,0,0,0,1, 0, 32'hDEAD0020, 1, 32'h100, 32'h100, 32'h0,      32'h20, 0, 0);
    add(0,0,0,0,1, 0, 32'h5555FFFE, 1, 32'h100, 32'h104, 32'h5555FFFE, 32'h104, 1, 0);
    // Branch: 0x104 + (-2 << 2) = 0xFC, fetched data dropped
    add(0,0,0,1,1, 0, 32'h66660104, 1, 32'h104, 32'hFC, 32'h0,       32'h104, 0, 0);
    // jr + jump together: jr wins, low PC bits taken as-is
    add(0,1,1,0,1, 32'h202, 32'h77770000, 1, 32'hFC, 32'h202, 32'h0, 32'h104, 0, 0);
    // Redirect in WAIT with ready=0, then wrap at 0xFFFFFFFC
    add(0,0,0,0,0, 0, 32'h0,        1, 32'h202, 32'h202, 32'h0,      32'h104, 0, 1);
    add(0,1,0,0,0, 32'hFFFFFFFC, 32'h0, 1, 32'h202, 32'hFFFFFFFC, 32'h0, 32'h104, 0, 1);
    add(0,0,0,0,1, 0, 32'hDEAD0202, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0, 32'h104, 0, 0);
    add(0,0,0,0,1, 0, 32'h77777777, 1, 32'hFFFFFFFC, 32'h0, 32'h77777777, 32'h0, 1, 0);
    // Redirect from HOLD empties the buffer
    add(0,0,0,0,0, 0, 32'h0,        1, 32'h0,   32'h0,   32'h0,      32'h0,  0, 1);
    add(1,0,0,0,1, 0, 32'h88888888, 1, 32'h0,   32'h0,   32'h0,      32'h0,  0, 1);
    add(1,1,0,0,0, 32'h300, 32'h0,  0, 32'h0,   32'h300, 32'h0,      32'h0,  0, 0);
    add(1,0,0,0,0, 0, 32'h0,        0, 32'h300, 32'h300, 32'h0,      32'h0,  0, 0);
    add(0,0,0,0,1, 0, 32'h99999999, 1, 32'h300, 32'h304, 32'h99999999, 32'h304, 1, 0);

    // Asynchronous reset state, before any clock edge
    #3;
    check_regs("rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);

    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("first_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("first_addr", imem_bus.imem_addr, 32'h0);

    foreach (vecs[i]) begin
      wpcir = vecs[i].wpcir; jr = vecs[i].jr; jump = vecs[i].jump;
      branch = vecs[i].branch; jr_target = vecs[i].jr_target;
      imem_bus.imem_ready = vecs[i].ready;
      imem_bus.imem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_req", i), {31'd0, imem_bus.imem_req},
            {31'd0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
      @(posedge clk); #1;
      check_regs($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_inst,
                 vecs[i].exp_pc4, vecs[i].exp_valid, vecs[i].exp_busy);
    end
    wpcir = 1'b0; jr = 1'b0; jump = 1'b0; branch = 1'b0;

    // Reset while WAIT is outstanding; ready during reset is ignored
    imem_bus.imem_ready = 1'b0;
    @(posedge clk); #1;
    check("mw_busy", {31'd0, fetch_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_regs("mw_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("mw_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    check_regs("mw_spur", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    imem_bus.imem_ready = 1'b0;
    #1;
    check("mw_req",  {31'd0, imem_bus.imem_req}, 32'd1);
    check("mw_addr", imem_bus.imem_addr, 32'h0);
    @(posedge clk); #1;
    check_regs("mw_wait", 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = 32'hAAAA0000;
    @(posedge clk); #1;
    check_regs("mw_done", 32'h4, 32'hAAAA0000, 32'h4, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
